// File: rtl/udp_cmd_fifo_reader_if.sv
// FIFO read port and command bus bundle for the UDP command FIFO reader.
interface udp_cmd_fifo_reader_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  fifo_rd_en;
    logic [DATA_WIDTH:0]   fifo_rd_data;
    logic                  fifo_rd_empty;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_wr;
    logic [DATA_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  cmd_last;
    logic                  busy;
    logic                  err_pulse;
    logic [7:0]            err_cnt;

    modport master (
        output fifo_rd_en,
        input  fifo_rd_data,
        input  fifo_rd_empty,
        output cmd_valid,
        input  cmd_ready,
        output cmd_wr,
        output cmd_addr,
        output cmd_wdata,
        output cmd_last,
        output busy,
        output err_pulse,
        output err_cnt
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_data,
        output fifo_rd_empty,
        input  cmd_valid,
        output cmd_ready,
        input  cmd_wr,
        input  cmd_addr,
        input  cmd_wdata,
        input  cmd_last,
        input  busy,
        input  err_pulse,
        input  err_cnt
    );
endinterface

// File: rtl/udp_cmd_fifo_reader.sv
// Pops framed words from the UDP command FIFO and issues per-beat register
// write/read requests on a valid/ready command bus.
module udp_cmd_fifo_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned ADDR_STEP  = 4
) (
    input  logic clk,
    input  logic tb_rst,
    udp_cmd_fifo_reader_if.master bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    localparam logic [7:0] OP_WR = 8'h01;
    localparam logic [7:0] OP_RD = 8'h02;

    logic [2:0]            state_q,  state_d;
    logic                  rd_en_q,  rd_en_d;
    logic                  pend_q,   pend_d;
    logic                  wr_q,     wr_d;
    logic [LEN_WIDTH-1:0]  len_q,    len_d;
    logic [LEN_WIDTH-1:0]  beat_q,   beat_d;
    logic [DATA_WIDTH-1:0] addr_q,   addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
    logic                  valid_q,  valid_d;
    logic                  last_q,   last_d;
    logic                  busy_q,   busy_d;
    logic                  err_q,    err_d;
    logic [7:0]            errcnt_q, errcnt_d;

    logic                  sop;
    logic [7:0]            opcode;
    logic                  take_hdr;
    logic                  fetch_ok;

    assign sop    = bus.fifo_rd_data[DATA_WIDTH];
    assign opcode = bus.fifo_rd_data[DATA_WIDTH-1 -: 8];

    // Framing FSM; pend_q marks the cycle in which a fetched word is captured.
    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        len_d    = len_q;
        beat_d   = beat_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = 1'b0;
        take_hdr = 1'b0;
        pend_d   = rd_en_q;

        case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    if (sop) take_hdr = 1'b1;
                    else     err_d    = 1'b1;
                end
            end
            S_ADDR: begin
                if (pend_q) begin
                    if (!sop) begin
                        addr_d  = bus.fifo_rd_data[DATA_WIDTH-1:0];
                        state_d = wr_q ? S_DATA : S_ISSUE;
                    end else begin
                        err_d    = 1'b1;
                        take_hdr = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (pend_q) begin
                    if (!sop) begin
                        wdata_d = bus.fifo_rd_data[DATA_WIDTH-1:0];
                        state_d = S_ISSUE;
                    end else begin
                        err_d    = 1'b1;
                        take_hdr = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (valid_q && bus.cmd_ready) begin
                    beat_d = beat_q + LEN_WIDTH'(1);
                    addr_d = addr_q + DATA_WIDTH'(ADDR_STEP);
                    if (last_q)    state_d = S_IDLE;
                    else if (wr_q) state_d = S_DATA;
                end
            end
            S_DRAIN: begin
                if (pend_q && sop) take_hdr = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Header decode, shared by IDLE and every resync path.
        if (take_hdr) begin
            if (opcode == OP_WR || opcode == OP_RD) begin
                wr_d    = (opcode == OP_WR);
                len_d   = bus.fifo_rd_data[LEN_WIDTH-1:0];
                beat_d  = '0;
                wdata_d = '0;
                state_d = S_ADDR;
            end else begin
                err_d   = 1'b1;
                state_d = S_DRAIN;
            end
        end

        fetch_ok = (state_d == S_IDLE) || (state_d == S_ADDR) ||
                   (state_d == S_DATA) || (state_d == S_DRAIN);
        rd_en_d  = fetch_ok && !bus.fifo_rd_empty && !rd_en_q;

        valid_d  = (state_d == S_ISSUE);
        last_d   = (state_d == S_ISSUE) && (beat_d == len_d);
        busy_d   = (state_d != S_IDLE);
        errcnt_d = (err_d && errcnt_q != 8'hFF) ? errcnt_q + 8'd1 : errcnt_q;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            state_q  <= S_IDLE;
            rd_en_q  <= 1'b0;
            pend_q   <= 1'b0;
            wr_q     <= 1'b0;
            len_q    <= '0;
            beat_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            errcnt_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            rd_en_q  <= rd_en_d;
            pend_q   <= pend_d;
            wr_q     <= wr_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign bus.fifo_rd_en = rd_en_q;
    assign bus.cmd_valid  = valid_q;
    assign bus.cmd_wr     = wr_q;
    assign bus.cmd_addr   = addr_q;
    assign bus.cmd_wdata  = wdata_q;
    assign bus.cmd_last   = last_q;
    assign bus.busy       = busy_q;
    assign bus.err_pulse  = err_q;
    assign bus.err_cnt    = errcnt_q;

endmodule

// File: doc/udp_cmd_fifo_reader.md
Name: udp_cmd_fifo_reader

Overview:
- Consumer end of the 33-bit UDP command FIFO: pops words from the synchronous FIFO read port, frames them into commands and issues per-beat register write/read requests on a valid/ready command bus.
- Sits between the FIFO read side and the lab register/AXI-lite bridge, in the same single clk domain as the FIFO.
- Word format: bit 32 = SOP flag, bits 31:0 = payload.

Parameters:
- DATA_WIDTH, 32, payload width; FIFO word width = DATA_WIDTH+1.
- LEN_WIDTH, 8, width of the header beat-count field.
- ADDR_STEP, 4, address increment per beat.

Ports:
- clk  in  1  clock.
- tb_rst  in  1  reset, asynchronous, active-high.
- fifo_rd_en  out  1  FIFO pop strobe.
- fifo_rd_data  in  DATA_WIDTH+1  FIFO read data, valid the cycle after fifo_rd_en (non-registered FIFO output).
- fifo_rd_empty  in  1  FIFO empty.
- cmd_valid  out  1  bus request valid.
- cmd_ready  in  1  bus accepts request.
- cmd_wr  out  1  1 = write beat, 0 = read beat.
- cmd_addr  out  DATA_WIDTH  beat address.
- cmd_wdata  out  DATA_WIDTH  write data; 0 for reads.
- cmd_last  out  1  final beat of the command.
- busy  out  1  high in any state other than IDLE.
- err_pulse  out  1  one-cycle pulse per framing error.
- err_cnt  out  8  saturating framing-error count.

Behaviour:
- Header word: SOP=1, [31:24] opcode (0x01 write, 0x02 read), [LEN_WIDTH-1:0] len; beats = len+1 (1..256). Remaining header bits are ignored.
- Address word: SOP=0, the start address.
- Write commands: beats data words follow, each SOP=0. Read commands: no data words are consumed.
- Fetch rule:
  - fifo_rd_en is a single-cycle pulse, asserted only when fifo_rd_empty=0 and no fetch is outstanding.
  - The word is captured the following cycle.
  - fifo_rd_en is never asserted while the FSM is in ISSUE.
- States:
  - IDLE: fetch a word. SOP=1 with a valid opcode -> latch opcode and len, go to ADDR. SOP=1 with an invalid opcode -> err, go to DRAIN. SOP=0 -> discard the word, err, stay in IDLE.
  - ADDR: fetch a word. SOP=0 -> latch address; a write goes to DATA, a read goes to ISSUE. SOP=1 -> err, reprocess the word as a new header (resync).
  - DATA: fetch a word. SOP=0 -> latch cmd_wdata, go to ISSUE. SOP=1 -> err, abort the command, reprocess the word as a header.
  - ISSUE: hold cmd_valid=1 with cmd_addr/cmd_wdata/cmd_wr/cmd_last stable until cmd_ready.
    - On the handshake: beat_cnt+1 and address+ADDR_STEP (modulo 2^DATA_WIDTH, wraps).
    - If it was the last beat, go to IDLE; otherwise go to DATA (write) or stay in ISSUE (read, next beat on the next cycle).
  - DRAIN: fetch and discard words until a word with SOP=1 arrives, then reprocess that word as a header.
- cmd_last = 1 exactly when beat_cnt == len.
- Read beats back-to-back when cmd_ready is held high: one beat per cycle.
- Write throughput: at most one beat per 3 cycles (fetch, capture, issue).
- An empty FIFO in any fetching state stalls in that state indefinitely. There is no timeout.
- err_pulse fires in the capture cycle. err_cnt increments on each err_pulse and saturates at 255.
- Reset values: all outputs 0, state IDLE, internal counters 0.
- A reset asserted mid-command aborts immediately. A word fetched but not yet captured is lost.

Test Plan:
- Write command: header 0x1_01000002, address 0x0_00001000, data 0xA, 0xB, 0xC; cmd_ready=1 -> three write beats at 0x1000/0x1004/0x1008 carrying 0xA/0xB/0xC, cmd_last only on the third, err_cnt=0.
- Read command: header 0x1_02000003, address 0x0_FFFFFFF8; cmd_ready=1 -> four read beats on consecutive cycles at 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4 (address wrap), cmd_wdata=0.
- Backpressure: same write command with cmd_ready low for 5 cycles on beat 2 -> beat-2 outputs stable throughout, no extra fifo_rd_en, completes after cmd_ready rises.
- Framing errors:
  - Stray word 0x0_12345678 in IDLE -> err_pulse, err_cnt=1.
  - Header with opcode 0x07 followed by 0x0_1, 0x0_2 and then a valid read header -> err_cnt=2, both junk words drained, read executes normally.
  - A SOP word arriving in DATA -> abort and resync, err_cnt increments.
- Empty stalls: FIFO empties between the address and data words -> fifo_rd_en stays low, busy=1, command resumes when data arrives.
- Reset mid-command: assert tb_rst during beat 2 of a 4-beat write -> all outputs 0 asynchronously; after release, the next full command executes correctly.
